// File: rtl/uart_pkg.sv
// Shared constants, register bit positions and the FSM state type for uart_lite_core.
package uart_pkg;
  localparam logic [1:0] ADR_DATA = 2'd0;
  localparam logic [1:0] ADR_CTRL = 2'd1;
  localparam logic [1:0] ADR_STAT = 2'd2;
  localparam logic [1:0] ADR_DIV  = 2'd3;

  localparam int CTRL_RXIE = 0;
  localparam int CTRL_TXIE = 1;
  localparam int CTRL_SW0  = 2;
  localparam int CTRL_SW1  = 3;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_TX_BUSY  = 2;
  localparam int STAT_OVERRUN  = 3;
  localparam int STAT_FRAMING  = 4;

  localparam logic [7:0] DIV_MIN = 8'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  function automatic logic [7:0] div_clamp(input logic [7:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction
endpackage

// File: rtl/uart_lite_core_if.sv
// Host-side register bus strobes of uart_lite_core; the data lines stay a tristate port on the core.
interface uart_lite_core_if;
  logic       ce;
  logic       we;
  logic [1:0] adr;

  modport master (output ce, we, adr);
  modport slave  (input  ce, we, adr);
endinterface

// File: rtl/uart_rx_deser.sv
// RX deserializer: 2-flop synchronizer, start-bit qualification, mid-bit sampling of an 8N1 frame.
module uart_rx_deser
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i_rx,
  input  logic [7:0] i_div,
  output logic       o_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);
  // r_sync[1:0] is the synchronizer, r_sync[2] the previous synchronized level for edge detection
  logic [2:0]  r_sync;
  uart_state_e r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_period;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit;
  logic        w_line;
  logic        w_fall;
  logic        w_mid;
  logic        w_tick;

  assign w_line      = r_sync[1];
  assign w_fall      = r_sync[2] & ~r_sync[1];
  assign w_mid       = (r_cnt == ((r_period >> 1) - 8'd1));
  assign w_tick      = (r_cnt == (r_period - 8'd1));
  assign o_valid     = (r_state == S_STOP) && w_tick && w_line;
  assign o_frame_err = (r_state == S_STOP) && w_tick && !w_line;
  assign o_byte      = r_shift;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sync   <= 3'b111;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_period <= DIV_MIN;
      r_shift  <= '0;
      r_bit    <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_rx};
      r_cnt  <= r_cnt + 8'd1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_state  <= S_START;
            r_period <= i_div;
          end
        end
        S_START: begin
          if (w_mid) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_period <= i_div;
            r_state  <= w_line ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt    <= '0;
            r_period <= i_div;
            r_shift  <= {w_line, r_shift[7:1]};
            r_bit    <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_lite_core.sv
// Register-mapped 8N1 UART: host register file, TX holding register and serializer, RX buffer.
// Define UART_RX_FIFO_EN to replace the single-byte RX buffer with a 4-entry FIFO.
module uart_lite_core
  import uart_pkg::*;
#(
  parameter logic [7:0] DIV_RST = 8'd16
) (
  input  logic             clk,
  input  logic             arst_n,
  uart_lite_core_if.slave  bus,
  inout  wire  [7:0]       dat,
  input  logic             rx,
  output logic             tx,
  output logic             inter
);
  logic        w_wr, w_rd, w_pop, w_stat_rd;
  logic [7:0]  w_wdata, w_rd_data, w_stat;
  logic [3:0]  r_ctrl;
  logic [7:0]  r_div;
  logic        r_ovr, r_ferr;
  logic        w_rx_valid, w_rx_ferr, w_rx_avail, w_rx_overrun, w_pop_ok, w_push_ok;
  logic [7:0]  w_rx_byte, w_rx_head;
  logic [1:0]  w_rx_level;
  uart_state_e r_tx_state;
  logic [7:0]  r_hold, r_tx_shift, r_tx_cnt, r_tx_period;
  logic        r_hold_full, r_tx;
  logic [2:0]  r_tx_bit;
  logic        w_tx_tick;

  assign w_wr      = bus.ce & bus.we;
  assign w_rd      = bus.ce & ~bus.we;
  assign w_pop     = w_rd & (bus.adr == ADR_DATA);
  assign w_stat_rd = w_rd & (bus.adr == ADR_STAT);
  assign w_wdata   = dat;
  assign dat       = w_rd ? w_rd_data : 8'bz;
  assign tx        = r_tx;
  assign inter     = (r_ctrl[CTRL_RXIE] & w_rx_avail) | (r_ctrl[CTRL_TXIE] & ~r_hold_full)
                   | r_ctrl[CTRL_SW0] | r_ctrl[CTRL_SW1];

  uart_rx_deser u_rx (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_rx        (rx),
    .i_div       (r_div),
    .o_valid     (w_rx_valid),
    .o_byte      (w_rx_byte),
    .o_frame_err (w_rx_ferr)
  );

`ifdef UART_RX_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_rd_ptr, r_wr_ptr;
  logic [2:0] r_count;

  assign w_rx_avail = (r_count != 3'd0);
  assign w_rx_head  = w_rx_avail ? r_fifo[r_rd_ptr] : 8'h00;
  assign w_rx_level = w_rx_avail ? 2'(r_count - 3'd1) : 2'd0;
  assign w_pop_ok   = w_pop & w_rx_avail;
  // A pop on the same edge frees the slot the push needs
  assign w_push_ok  = w_rx_valid & ((r_count != 3'd4) | w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= w_rx_byte;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= r_count + {2'b00, w_push_ok} - {2'b00, w_pop_ok};
    end
  end
`else
  logic [7:0] r_rx_data;
  logic       r_rx_full;

  assign w_rx_avail = r_rx_full;
  assign w_rx_head  = r_rx_full ? r_rx_data : 8'h00;
  assign w_rx_level = 2'd0;
  assign w_pop_ok   = w_pop & r_rx_full;
  assign w_push_ok  = w_rx_valid & (~r_rx_full | w_pop_ok);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rx_data <= '0;
      r_rx_full <= 1'b0;
    end else if (w_push_ok) begin
      r_rx_data <= w_rx_byte;
      r_rx_full <= 1'b1;
    end else if (w_pop_ok) begin
      r_rx_full <= 1'b0;
    end
  end
`endif

  assign w_rx_overrun = w_rx_valid & ~w_push_ok;

  always_comb begin
    w_stat                = '0;
    w_stat[STAT_RX_AVAIL] = w_rx_avail;
    w_stat[STAT_TX_EMPTY] = ~r_hold_full;
    w_stat[STAT_TX_BUSY]  = (r_tx_state != S_IDLE);
    w_stat[STAT_OVERRUN]  = r_ovr;
    w_stat[STAT_FRAMING]  = r_ferr;
    w_stat[6:5]           = w_rx_level;
  end

  always_comb begin
    case (bus.adr)
      ADR_DATA: w_rd_data = w_rx_head;
      ADR_CTRL: w_rd_data = {4'h0, r_ctrl};
      ADR_STAT: w_rd_data = w_stat;
      default:  w_rd_data = r_div;
    endcase
  end

  // Error flags: a same-edge event wins over the clear-on-read
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ctrl <= '0;
      r_div  <= DIV_RST;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_wr && bus.adr == ADR_CTRL) r_ctrl <= w_wdata[3:0];
      if (w_wr && bus.adr == ADR_DIV)  r_div  <= div_clamp(w_wdata);
      if (w_stat_rd) begin
        r_ovr  <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (w_rx_overrun) r_ovr  <= 1'b1;
      if (w_rx_ferr)    r_ferr <= 1'b1;
    end
  end

  assign w_tx_tick = (r_tx_cnt == (r_tx_period - 8'd1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_tx_state  <= S_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_shift  <= '0;
      r_tx_cnt    <= '0;
      r_tx_period <= DIV_MIN;
      r_tx_bit    <= '0;
      r_tx        <= 1'b1;
    end else begin
      if (w_wr && bus.adr == ADR_DATA && !r_hold_full) begin
        r_hold      <= w_wdata;
        r_hold_full <= 1'b1;
      end
      r_tx_cnt <= r_tx_cnt + 8'd1;
      case (r_tx_state)
        S_IDLE: begin
          r_tx_cnt <= '0;
          if (r_hold_full) begin
            r_tx_state  <= S_START;
            r_tx_shift  <= r_hold;
            r_hold_full <= 1'b0;
            r_tx_period <= r_div;
            r_tx        <= 1'b0;
          end
        end
        S_START: begin
          if (w_tx_tick) begin
            r_tx_cnt    <= '0;
            r_tx_period <= r_div;
            r_tx_bit    <= '0;
            r_tx        <= r_tx_shift[0];
            r_tx_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tx_tick) begin
            r_tx_cnt    <= '0;
            r_tx_period <= r_div;
            r_tx_bit    <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_shift <= r_tx_shift >> 1;
              r_tx       <= r_tx_shift[1];
            end
          end
        end
        S_STOP: begin
          if (w_tx_tick) begin
            r_tx_cnt    <= '0;
            r_tx_period <= r_div;
            if (r_hold_full) begin
              r_tx_state  <= S_START;
              r_tx_shift  <= r_hold;
              r_hold_full <= 1'b0;
              r_tx        <= 1'b0;
            end else begin
              r_tx_state <= S_IDLE;
            end
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_lite_core.md
# uart_lite_core

- Register-mapped 8N1 UART: the responder side of the `clk`/`we`/`ce`/`adr`/`dat` host bus that benches drive.
- Serializes host-written bytes onto `tx` and deserializes `rx` into a readable buffer.
- Raises `inter` on enabled RX/TX events or software-forced interrupts.
- Sits between the host register bus and the serial pins; it is the DUT behind the bench interface.

## Interface
- `DIV_RST`, default 8'd16: reset value of the baud divisor (clocks per bit).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `arst_n`  in  1  reset, asynchronous and active-low.
- `ce`  in  1  bus access strobe.
- `we`  in  1  1 = write, 0 = read (qualified by `ce`).
- `adr`  in  2  register select: 0 DATA, 1 CTRL, 2 STAT, 3 DIV.
- `dat`  inout  8  bus data. Driven by the block only while `ce & !we`, otherwise `'Z`.
- `rx`  in  1  serial input, asynchronous to `clk`.
- `tx`  out  1  serial output.
- `inter`  out  1  level interrupt.

## Operation
Register map:
- **DATA write:** loads the TX holding register if it is empty; the write is dropped if it is full.
- **DATA read:** returns the RX head; 0x00 if the buffer is empty.
- **CTRL (r/w):**
  - bit0 RXIE, bit1 TXIE.
  - bit2 and bit3: software interrupt bits, sticky, cleared only by writing 0.
  - bits 7:4 read 0.
- **STAT (read-only):**
  - bit0 rx_avail, bit1 tx_hold_empty, bit2 tx_busy, bit3 overrun, bit4 framing_err.
  - A read clears bits 3–4 at the edge ending the read cycle.
- **DIV (r/w):** bit period in clocks. Written values 0 and 1 are stored as 2.

Interrupt:
- `inter = (RXIE & rx_avail) | (TXIE & tx_hold_empty) | CTRL[2] | CTRL[3]`, combinational from registers.

TX FSM (IDLE, START, DATA, STOP):
- IDLE → START when the holding register is full; the holding byte moves to the shifter and the holding register becomes empty in the same edge.
- START: `tx`=0 for DIV clocks.
- DATA: 8 bits, LSB first, DIV clocks each.
- STOP: `tx`=1 for DIV clocks. Then → START if holding is full, else IDLE.

RX FSM (IDLE, START, DATA, STOP):
- `rx` passes through a 2-flop synchronizer.
- IDLE → START on a synchronized falling edge.
- START: samples at DIV/2 (integer division). If the line is high, it is a glitch → IDLE.
- DATA: samples each bit every DIV clocks at mid-bit.
- STOP: samples mid-bit.
  - Stop bit = 0: set framing_err, discard the byte.
  - Stop bit = 1: push the byte; if the buffer is full, drop the new byte and set overrun.

RX buffer:
- Single byte (see Configuration).
- Pop on a DATA read (`ce & !we & adr==0`) at that edge.
- Pop and push on the same edge: the pop is applied first, the push then succeeds, no overrun.

Reset values:
- `tx`=1, `inter`=0, `dat`='Z.
- CTRL=0, STAT=8'h02, DIV=`DIV_RST`.
- Both FSMs in IDLE, buffers empty.
- Asserting `arst_n` mid-frame aborts the frame immediately; `tx` returns to 1.

## Timing
- Reads: `dat` is valid combinationally during the cycle `ce & !we` is high, so the host captures it at the next edge.
- Writes: take effect at the edge sampling `ce & we`.
- `inter` follows register state with zero added latency. A CTRL write with bit2 or bit3 set, sampled at edge k, gives `inter`=1 at edge k+1.
- TX latency: `tx` falls on the first edge after the DATA write (TX idle).
- TX frame: exactly 10×DIV clocks.
- RX latency: rx_avail rises 2 sync cycles plus 9.5×DIV clocks after the start-bit falling edge.
- DIV writes apply at the next bit boundary; the bit in progress keeps its old period.

## Configuration
- **`UART_RX_FIFO_EN` defined:**
  - The RX buffer is a 4-entry FIFO with 2-bit pointers that wrap modulo 4.
  - rx_avail = not empty; overrun when a push occurs while 4 entries are held.
  - STAT bits 6:5 = occupancy−1 when not empty, else 0.
- **Undefined:** single-byte buffer; STAT bits 6:5 read 0.

## Structure
- `uart_pkg`: address constants (`ADR_DATA`, `ADR_CTRL`, `ADR_STAT`, `ADR_DIV`), STAT/CTRL bit indices, the `uart_state_e` enum shared by both FSMs, and `DIV_MIN`=2.
- Sub-module `uart_rx_deser`: synchronizer, RX FSM and bit counter. Outputs a byte-valid pulse, the byte, and the framing-error pulse.
- TX FSM, registers, RX buffer and the bus tristate live in the top.

## Test plan
- Reset, then read all four addresses → DATA 0x00, CTRL 0x00, STAT 0x02, DIV 0x10; `tx`=1, `inter`=0.
- Write CTRL=0x04 → `inter`=1 at the next edge. Write CTRL=0x00 → `inter`=0. Repeat with 0x08.
- DIV=4, write DATA=0xA5 → `tx` pattern 0,1,0,1,0,0,1,0,1,1, each 4 clocks (40 total); STAT bit2 high throughout.
- Drive `rx` frame 0x3C at DIV=4 with CTRL=0x01 → `inter`=1 and STAT bit0=1. Read DATA → 0x3C, then `inter`=0.
- Two frames with no read (FIFO build: five) → STAT bit3=1, first byte retained. Read STAT → bit3 cleared.
- Frame with stop bit 0 → STAT bit4=1, rx_avail unchanged. A DATA read landing on the push edge → no overrun, new byte readable.
